adder_flit_injector: RTL and testbench

- Synthesizable upstream stage for the adder characterization bench.
- Accepts 2N-bit flits from a valid/ready source and splits each flit into the adder's two N-bit operands, held in registers.
- Paces injection as packets of PAYLOAD flits separated by GAP idle cycles, for NUM_PKTS packets per run.
- Controls link utilization, and therefore operand switching activity, for energy characterization.

---
 rtl/adder_char_pkg.sv | 15 +
 rtl/char_down_counter.sv | 39 +++
 rtl/adder_flit_injector.sv | 158 +++++++++++++++
 tb/tb_adder_flit_injector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_char_pkg.sv
// Shared widths and state encoding for the adder characterization front end.
package adder_char_pkg;

  localparam int OPERAND_W = 22;
  localparam int FLIT_W    = 2 * OPERAND_W;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } inj_state_t;

endpackage

// File: rtl/char_down_counter.sv
// Loadable CNT_W-bit down-counter with a zero flag; saturates at zero.
module char_down_counter
  import adder_char_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/adder_flit_injector.sv
// Paced flit injector feeding the adder operands as packets separated by idle gaps.
// Optional build macro INJ_ZERO_IDLE_EN clears the operands outside SEND.
module adder_flit_injector
  import adder_char_pkg::*;
#(
  parameter int N        = OPERAND_W,
  parameter int PAYLOAD  = 20,
  parameter int GAP      = 7,
  parameter int NUM_PKTS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [2*N-1:0]   in_data,
  output logic             in_ready,
  output logic [N-1:0]     input1,
  output logic [N-1:0]     input2,
  output logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] flit_cnt
);

  generate
    if ((N < 1) || (PAYLOAD < 1) || (PAYLOAD > 65535) || (GAP < 0) || (GAP > 65535) ||
        (NUM_PKTS < 1) || (NUM_PKTS > 65535)) begin : g_bad_param
      $error("adder_flit_injector: parameter out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(PAYLOAD - 1);
  localparam logic [CNT_W-1:0] LAST_PKT  = CNT_W'(NUM_PKTS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit               GAP_EN    = (GAP > 0);

  inj_state_t       state_q, state_d;
  logic [N-1:0]     input1_q, input1_d;
  logic [N-1:0]     input2_q, input2_d;
  logic             op_valid_q, op_valid_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
  logic             accept_s;
  logic             gap_load_s;
  logic             gap_dec_s;
  logic             gap_zero_s;

  assign accept_s = in_valid && (state_q == SEND);

  char_down_counter u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load_s),
    .dec      (gap_dec_s),
    .load_val (GAP_LOAD),
    .zero     (gap_zero_s)
  );

  // Next-state, counter and operand logic. The GAP state is package-qualified
  // because the GAP parameter shadows the imported enum literal.
  always_comb begin
    state_d    = state_q;
    input1_d   = input1_q;
    input2_d   = input2_q;
    op_valid_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    gap_load_s = 1'b0;
    gap_dec_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SEND;
          pkt_cnt_d  = {CNT_W{1'b0}};
          flit_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (accept_s) begin
          input1_d   = in_data[N-1:0];
          input2_d   = in_data[2*N-1:N];
          op_valid_d = 1'b1;
          if (flit_cnt_q == LAST_FLIT) begin
            flit_cnt_d = {CNT_W{1'b0}};
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
            if (pkt_cnt_q == LAST_PKT) begin
              state_d = DONE;
            end else if (GAP_EN) begin
              state_d    = adder_char_pkg::GAP;
              gap_load_s = 1'b1;
            end else begin
              state_d = SEND;
            end
          end else begin
            flit_cnt_d = flit_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      adder_char_pkg::GAP: begin
        if (gap_zero_s) begin
          state_d = SEND;
        end else begin
          gap_dec_s = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef INJ_ZERO_IDLE_EN
    // Gated link: operands clear on the edge that leaves SEND.
    if (state_d != SEND) begin
      input1_d = {N{1'b0}};
      input2_d = {N{1'b0}};
    end else begin
      input1_d = input1_d;
      input2_d = input2_d;
    end
`endif
  end

  // State, operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      input1_q   <= {N{1'b0}};
      input2_q   <= {N{1'b0}};
      op_valid_q <= 1'b0;
      pkt_cnt_q  <= {CNT_W{1'b0}};
      flit_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      input1_q   <= input1_d;
      input2_q   <= input2_d;
      op_valid_q <= op_valid_d;
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign in_ready = (state_q == SEND);
  assign busy     = (state_q == SEND) || (state_q == adder_char_pkg::GAP);
  assign done     = (state_q == DONE);
  assign input1   = input1_q;
  assign input2   = input2_q;
  assign op_valid = op_valid_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_adder_flit_injector.sv
// Self-checking bench for adder_flit_injector: reference model, split table, stall, reset and zero-gap cases.
module tb_adder_flit_injector;

  localparam int NW = 22;
  localparam int P  = 20;
  localparam int G  = 7;
  localparam int NP = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [2*NW-1:0] in_data = '0;
  logic            in_ready, op_valid, busy, done;
  logic [NW-1:0]   input1, input2;
  logic [15:0]     pkt_cnt, flit_cnt;

  logic            start_b = 1'b0;
  logic            in_valid_b = 1'b0;
  logic [2*NW-1:0] in_data_b = '0;
  logic            in_ready_b, op_valid_b, busy_b, done_b;
  logic [NW-1:0]   input1_b, input2_b;
  logic [15:0]     pkt_cnt_b, flit_cnt_b;

  always #5 clk = ~clk;

  adder_flit_injector #(.N(NW), .PAYLOAD(P), .GAP(G), .NUM_PKTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .input1(input1), .input2(input2), .op_valid(op_valid),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
  );

  adder_flit_injector #(.N(NW), .PAYLOAD(3), .GAP(0), .NUM_PKTS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .input1(input1_b), .input2(input2_b), .op_valid(op_valid_b),
    .busy(busy_b), .done(done_b), .pkt_cnt(pkt_cnt_b), .flit_cnt(flit_cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a count of accepted flits plus a pending gap length.
  bit          m_running, m_done, m_opv;
  int          m_acc, m_gap;
  logic [NW-1:0] m_in1, m_in2;

  task automatic model_reset();
    m_running = 0; m_done = 0; m_opv = 0; m_acc = 0; m_gap = 0;
    m_in1 = '0; m_in2 = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_opv = 0;
      if (m_done) m_done = 0;
      else if (!m_running) begin
        if (start) begin m_running = 1; m_acc = 0; m_gap = 0; end
      end else if (m_gap > 0) m_gap--;
      else if (in_valid) begin
        m_opv = 1;
        m_in1 = in_data[NW-1:0];
        m_in2 = in_data[2*NW-1:NW];
        m_acc++;
        if (m_acc == P * NP) begin m_running = 0; m_done = 1; end
        else if (m_acc % P == 0) m_gap = G;
      end
`ifdef INJ_ZERO_IDLE_EN
      if (!m_running || m_gap > 0) begin m_in1 = '0; m_in2 = '0; end
`endif
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, m_running && m_gap == 0);
    chk("input1", input1, m_in1);
    chk("input2", input2, m_in2);
    chk("op_valid", op_valid, m_opv);
    chk("busy", busy, m_running);
    chk("done", done, m_done);
    chk("pkt_cnt", pkt_cnt, 16'(m_acc / P));
    chk("flit_cnt", flit_cnt, 16'(m_acc % P));
  endtask

  int busy_cnt, done_cnt, done_pkt, acc_cnt;

  task automatic cycle();
    @(negedge clk);
    check_all();
    if (busy) busy_cnt++;
    if (in_valid && in_ready) acc_cnt++;
    if (done) begin done_cnt++; done_pkt = int'(pkt_cnt); end
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [2*NW-1:0] data;
    logic [NW-1:0]   exp1;
    logic [NW-1:0]   exp2;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{44'hFFFFFE00000, 22'h200000, 22'h3FFFFF};
    tbl[1] = '{44'h00000400001, 22'h000001, 22'h000001};
    tbl[2] = '{44'hAAAAAAAAAAA, 22'h2AAAAA, 22'h2AAAAA};
    tbl[3] = '{44'h55555555555, 22'h155555, 22'h155555};

    // Reset state.
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Default run with incrementing flits.
    busy_cnt = 0; done_cnt = 0; done_pkt = 0;
    start = 1'b1; cycle(); start = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      in_data = 44'(m_acc + 1);
      cycle();
    end
    repeat (3) cycle();
    chk("run_done_once", 64'(done_cnt), 64'd1);
    chk("run_busy_cycles", 64'(busy_cnt), 64'd263);
    chk("run_pkt_at_done", 64'(done_pkt), 64'd10);

    // Operand split table, then a 5-cycle source stall after flit 4.
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].data;
      cycle();
      chk("split_in1", input1, tbl[i].exp1);
      chk("split_in2", input2, tbl[i].exp2);
      chk("split_opv", op_valid, 1'b1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_flit_cnt", flit_cnt, 16'd4);
      chk("stall_opv", op_valid, 1'b0);
      chk("stall_in1", input1, tbl[3].exp1);
    end
    acc_cnt = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && m_acc < P; c++) begin
      in_data = {$urandom, $urandom};
      cycle();
    end
    chk("stall_pkt_flits", 64'(acc_cnt), 64'd16);
    chk("stall_pkt_done", pkt_cnt, 16'd1);

    // Random traffic, random start pulses (including during runs and done).
    for (int c = 0; c < 900; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom, $urandom};
      start    = ($urandom_range(0, 15) == 0);
      cycle();
    end
    start = 1'b0;
    for (int c = 0; c < 400 && (m_running || m_done); c++) begin
      in_valid = 1'b1;
      cycle();
    end
    chk("random_run_drained", 64'(m_running), 64'd0);

    // Asynchronous reset at flit 10 of packet 3.
    start = 1'b1; cycle(); start = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && m_acc != 3 * P + 10; c++) begin
      in_data = 44'(m_acc + 1);
      cycle();
    end
    chk("rst_reached_point", 64'(m_acc), 64'(3 * P + 10));
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_in1", input1, 22'd0);
    chk("rst_in2", input2, 22'd0);
    chk("rst_opv", op_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pkt", pkt_cnt, 16'd0);
    chk("rst_flit", flit_cnt, 16'd0);
    model_reset();
    in_valid = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    start = 1'b1; cycle(); start = 1'b0;
    chk("fresh_busy", busy, 1'b1);
    chk("fresh_pkt", pkt_cnt, 16'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 400 && (m_running || m_done); c++) begin
      in_data = 44'(m_acc + 1);
      cycle();
    end

    // Zero-gap instance: six back-to-back acceptances, then done.
    begin
      int acc_b = 0;
      bit drop = 0;
      @(posedge clk); #1;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      in_valid_b = 1'b1;
      in_data_b = 44'd1;
      for (int c = 0; c < 20 && acc_b < 6; c++) begin
        @(negedge clk);
        if (!in_ready_b) drop = 1;
        else begin
          acc_b++;
          if (acc_b < 6) in_data_b = 44'(acc_b + 1);
        end
      end
      @(negedge clk);
      in_valid_b = 1'b0;
      chk("b_accepts", 64'(acc_b), 64'd6);
      chk("b_ready_steady", 64'(drop), 64'd0);
      chk("b_done", done_b, 1'b1);
      chk("b_pkt", pkt_cnt_b, 16'd2);
`ifdef INJ_ZERO_IDLE_EN
      chk("b_in1_after", input1_b, 22'd0);
`else
      chk("b_in1_after", input1_b, 22'd6);
`endif
      @(negedge clk);
      chk("b_done_once", done_b, 1'b0);
      chk("b_idle_ready", in_ready_b, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
